// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: segment patterns and digit type shared by the seconds counter and its decoder.
package seven_seg_pkg;
    typedef logic [3:0] digit_t;
    localparam digit_t DIGIT_MAX = 4'd9;
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;
endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder: combinational digit to active-high {g,f,e,d,c,b,a} segments.
module seg7_decoder
    import seven_seg_pkg::*;
(
    input  digit_t     digit,
    output logic [6:0] seg
);
    always_comb begin
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/seven_seg_seconds.sv
// seven_seg_seconds: one-digit seconds counter on a seven-segment display.
// Define DP_BLINK_EN to blink the decimal point at 1 Hz in phase with the digit.
module seven_seg_seconds
    import seven_seg_pkg::*;
#(
    parameter int MAX_COUNT = 1000,
    parameter int CNT_W     = 24
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);
    logic             clk;
    logic             rst_n;
    logic             unused_in;
    logic [1:0]       sync;
    logic             rst_sync_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             tick;
    digit_t           digit;
    logic [6:0]       seg;

    assign clk        = io_in[0];
    assign rst_n      = io_in[1];
    assign unused_in  = ^io_in[7:2];
    assign rst_sync_n = sync[1];

    // Asserts immediately, releases two edges after rst_n rises.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync <= 2'b00;
        else        sync <= {sync[0], 1'b1};

    assign tick     = cnt == CNT_W'(MAX_COUNT - 1);
    assign cnt_next = tick ? '0 : cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_sync_n)
        if (!rst_sync_n) begin
            cnt   <= '0;
            digit <= '0;
        end else begin
            cnt <= cnt_next;
            if (tick) digit <= (digit >= DIGIT_MAX) ? '0 : digit + 4'd1;
        end

    seg7_decoder u_dec (
        .digit(digit),
        .seg  (seg)
    );

`ifdef DP_BLINK_EN
    logic dp;
    always_ff @(posedge clk or negedge rst_sync_n)
        if (!rst_sync_n) dp <= 1'b0;
        else             dp <= cnt_next < CNT_W'(MAX_COUNT / 2);
    assign io_out = {dp, seg};
`else
    assign io_out = {1'b0, seg};
`endif
endmodule

// File: tb/tb_seven_seg_seconds.sv
// tb_seven_seg_seconds: directed scoreboard bench for seven_seg_seconds with MAX_COUNT = 10.
module tb_seven_seg_seconds;
    typedef struct {
        logic [6:0] seg;
        int         edges;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] spare = '0;
    logic       noise = 1'b0;
    logic [7:0] io_out;
    int         checks = 0;
    int         errors = 0;
    exp_t       exp_q[$];
    logic [6:0] seq [10] = '{7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h3F, 7'h06};

    seven_seg_seconds #(.MAX_COUNT(10), .CNT_W(4)) dut (
        .io_in ({spare, rst_n, clk}),
        .io_out(io_out)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        if (noise) spare = 6'($urandom);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic step(input logic [6:0] seg, input int edges);
        exp_t e;
        logic [6:0] prev;
        int n;
        int dp_hi;
        exp_q.push_back('{seg, edges});
        prev = io_out[6:0];
        n = 0;
        dp_hi = 0;
        while (n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            dp_hi += int'(io_out[7]);
            if (io_out[6:0] !== prev) break;
        end
        e = exp_q.pop_front();
        chk("digit_seg", 32'(io_out[6:0]), 32'(e.seg));
        chk("digit_edges", 32'(n), 32'(e.edges));
`ifdef DP_BLINK_EN
        chk("dp_rise", 32'(io_out[7]), 32'd1);
        if (e.edges == 10) chk("dp_duty", 32'(dp_hi), 32'd5);
`else
        chk("dp_off", 32'(dp_hi), 32'd0);
`endif
    endtask

    task automatic run_sequence(input int hold);
        rst_n = 1'b0;
        repeat (hold) begin
            @(negedge clk);
            chk("reset_out", 32'(io_out), 32'h3F);
        end
        rst_n = 1'b1;
        step(7'h06, 12);
        for (int i = 0; i < 10; i++) step(seq[i], 10);
    endtask

    initial begin
        run_sequence(5);
        noise = 1'b1;
        run_sequence(3);
        noise = 1'b0;
        step(7'h5B, 10);
        step(7'h4F, 10);
        step(7'h66, 10);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", 32'(io_out), 32'h3F);
        @(negedge clk);
        chk("reset_hold", 32'(io_out), 32'h3F);
        rst_n = 1'b1;
        step(7'h06, 12);
        step(7'h5B, 10);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
